sram_arbiter: RTL and testbench

Two-port round-robin access controller for the 8×8 synchronous SRAM in the storage experiment. It clears the memory after reset, then serialises read/write requests from two independent requesters (A, B) onto the single memory port. It returns read data and a one-cycle acknowledge to whichever requester was served. It sits between the requesters and the memory array; the memory itself is external to this block.

---
 rtl/sram_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter
//
// Round-robin access controller placed between two requesters (A, B) and
// a single-port 8x8 synchronous SRAM. After reset it zero-fills the whole
// memory, then serves one request at a time. Each access takes four
// cycles: IDLE (grant), ACCESS (drive memory), CAPTURE (read data
// returns), and DONE (ack pulse).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata  requester A command, held until a_ack
//   b_req/b_we/b_addr/b_wdata  requester B command, held until b_ack
//   a_ack, b_ack             one-cycle completion pulse per requester
//   a_rdata, b_rdata         last read result per requester
//   mem_we/mem_addr/mem_wdata  memory command; the SRAM registers it
//   mem_rdata                memory read data, one cycle after mem_addr
//   busy                     high whenever the controller is not in IDLE
//
// All outputs come straight from registers. Each memory-side register is
// loaded on the edge that enters a state, with the value that state must
// present.

module sram_arbiter #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          a_ack,
    output logic          b_ack,
    output logic [DW-1:0] a_rdata,
    output logic [DW-1:0] b_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_ACCESS,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t        state_reg;
    logic [AW-1:0] clr_cnt_reg;
    logic          ptr_reg;     // round-robin pointer: 0 = A, 1 = B
    logic          grant_reg;   // port being served: 0 = A, 1 = B
    logic          we_reg;      // latched direction of the served request
    logic [1:0]    ack_reg;
    logic          busy_reg;
    logic          mem_we_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [DW-1:0] mem_wdata_reg;
    logic [DW-1:0] rdata_reg [2];

    // Per-port views of the request inputs, indexed by port id.
    logic [1:0]    req_vec;
    logic [1:0]    we_vec;
    logic [AW-1:0] addr_vec  [2];
    logic [DW-1:0] wdata_vec [2];
    logic          win_next;

    assign req_vec      = {b_req, a_req};
    assign we_vec       = {b_we, a_we};
    assign addr_vec[0]  = a_addr;
    assign addr_vec[1]  = b_addr;
    assign wdata_vec[0] = a_wdata;
    assign wdata_vec[1] = b_wdata;

    // A lone requester always wins; the pointer only decides ties.
    always_comb begin
        win_next = ptr_reg;
        if (req_vec == 2'b01) begin
            win_next = 1'b0;
        end else if (req_vec == 2'b10) begin
            win_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_CLEAR;
            clr_cnt_reg   <= '0;
            ptr_reg       <= 1'b0;
            grant_reg     <= 1'b0;
            we_reg        <= 1'b0;
            ack_reg       <= '0;
            busy_reg      <= 1'b1;
            // The first clear write (address 0) is presented straight
            // out of reset.
            mem_we_reg    <= 1'b1;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            // The memory command and the acks are quiet unless the state
            // being entered says otherwise.
            ack_reg       <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            case (state_reg)
                S_CLEAR: begin
                    if (clr_cnt_reg == '1) begin
                        state_reg   <= S_IDLE;
                        busy_reg    <= 1'b0;
                        clr_cnt_reg <= '0;
                    end else begin
                        clr_cnt_reg  <= clr_cnt_reg + 1'b1;
                        mem_we_reg   <= 1'b1;
                        mem_addr_reg <= clr_cnt_reg + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (|req_vec) begin
                        state_reg     <= S_ACCESS;
                        busy_reg      <= 1'b1;
                        grant_reg     <= win_next;
                        we_reg        <= we_vec[win_next];
                        ptr_reg       <= ~win_next;
                        mem_we_reg    <= we_vec[win_next];
                        mem_addr_reg  <= addr_vec[win_next];
                        mem_wdata_reg <= wdata_vec[win_next];
                    end
                end
                S_ACCESS: begin
                    state_reg <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    state_reg          <= S_DONE;
                    ack_reg[grant_reg] <= 1'b1;
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg   <= S_CLEAR;
                    clr_cnt_reg <= '0;
                    busy_reg    <= 1'b1;
                    mem_we_reg  <= 1'b1;
                end
            endcase
        end
    end

    // In CAPTURE the SRAM returns the word addressed during ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                rdata_reg[i] <= '0;
            end
        end else if (state_reg == S_CAPTURE && !we_reg) begin
            rdata_reg[grant_reg] <= mem_rdata;
        end
    end

    assign a_ack     = ack_reg[0];
    assign b_ack     = ack_reg[1];
    assign a_rdata   = rdata_reg[0];
    assign b_rdata   = rdata_reg[1];
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter. Contains a behavioural 8x8 synchronous SRAM
// with a registered read. Each expected acknowledge is queued when its
// request is issued. A monitor then pops the queue on every ack.

module tb_sram_arbiter;
    localparam int AW = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0, a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          a_ack, b_ack;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    // Non-zero power-up contents, so a missing clear is visible.
    logic [DW-1:0] mem [8] = '{default: 8'hEE};

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    bit hold_a = 1'b0;
    bit hold_b = 1'b0;

    typedef struct {
        bit            port;   // 0 = A, 1 = B
        bit            we;
        logic [DW-1:0] rdata;
        int            cyc;    // expected ack cycle, -1 = not timed
    } exp_t;

    exp_t exp_q[$];

    sram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_ack(a_ack), .b_ack(b_ack), .a_rdata(a_rdata), .b_rdata(b_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ack(input bit port, input bit we, input int rdata, input int dcyc);
        exp_t e;
        e.port  = port;
        e.we    = we;
        e.rdata = rdata[DW-1:0];
        e.cyc   = (dcyc < 0) ? -1 : cyc + dcyc;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit port, input bit we, input int addr, input int wdata);
        if (!port) begin
            a_we = we; a_addr = addr[AW-1:0]; a_wdata = wdata[DW-1:0]; a_req = 1'b1;
        end else begin
            b_we = we; b_addr = addr[AW-1:0]; b_wdata = wdata[DW-1:0]; b_req = 1'b1;
        end
    endtask

    task automatic issue(input bit port, input bit we, input int addr, input int wdata,
                         input int rdata, input int dcyc);
        expect_ack(port, we, rdata, dcyc);
        drive(port, we, addr, wdata);
    endtask

    // Returns at posedge+1 in a cycle where the DUT is in IDLE with no request.
    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while ((busy || a_req || b_req) && n < 200);
        check("idle_timeout", int'(busy || a_req || b_req), 0);
    endtask

    task automatic wait_acks(input int target);
        int n = 0;
        while (ack_cnt < target && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("ack_count", ack_cnt, target);
    endtask

    // Expects to start in the first cycle after reset is released.
    task automatic check_clear(input string tag);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check({tag, "_mem_we"}, mem_we, 1);
            check({tag, "_mem_addr"}, mem_addr, i);
            check({tag, "_mem_wdata"}, mem_wdata, 0);
            check({tag, "_busy"}, busy, 1);
            check({tag, "_a_rdata"}, a_rdata, 0);
            check({tag, "_b_rdata"}, b_rdata, 0);
        end
        @(negedge clk);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_mem_we"}, mem_we, 0);
    endtask

    // Monitor: compares every ack against the scoreboard, then releases
    // req in the cycle after the ack unless the requester is holding it.
    initial begin
        exp_t e;
        bit   port;
        bit   drop_a, drop_b;
        forever begin
            @(negedge clk);
            drop_a = 1'b0;
            drop_b = 1'b0;
            if (a_ack || b_ack) begin
                port = b_ack;
                ack_cnt++;
                check("ack_exclusive", int'(a_ack && b_ack), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack on port %s expected none (cycle %0d)",
                             port ? "B" : "A", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_port", port, e.port);
                    if (e.cyc >= 0) check("ack_cycle", cyc, e.cyc);
                    if (!e.we) check(port ? "b_rdata" : "a_rdata",
                                     port ? b_rdata : a_rdata, e.rdata);
                    $display("ack port %s %s rdata=%02h cycle %0d",
                             port ? "B" : "A", e.we ? "write" : "read",
                             port ? b_rdata : a_rdata, cyc);
                end
                drop_a = a_ack && !hold_a;
                drop_b = b_ack && !hold_b;
            end
            @(posedge clk); #2;
            if (drop_a) a_req = 1'b0;
            if (drop_b) b_req = 1'b0;
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got no finish expected finish by 20000");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while rst is held.
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_mem_we", mem_we, 1);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_a_ack", a_ack, 0);
        check("rst_b_ack", b_ack, 0);
        check("rst_a_rdata", a_rdata, 0);
        check("rst_b_rdata", b_rdata, 0);
        @(posedge clk); #1 rst = 1'b0;
        check_clear("por");

        // A writes 0xA5 @3, then reads it back.
        wait_idle();
        issue(0, 1, 3, 'hA5, 0, 3);
        wait_acks(1);
        wait_idle();
        issue(0, 0, 3, 0, 'hA5, 3);
        wait_acks(2);
        check("b_rdata_untouched", b_rdata, 0);

        // B holds req for three reads (3, then 7, then 0).
        wait_idle();
        hold_b = 1'b1;
        issue(1, 0, 3, 0, 'hA5, 3);
        expect_ack(1, 0, 'h00, 7);
        expect_ack(1, 0, 'h00, 11);
        wait_acks(3);
        @(posedge clk); #1 b_addr = 3'd7;
        wait_acks(4);
        @(posedge clk); #1 b_addr = 3'd0;
        hold_b = 1'b0;
        wait_acks(5);

        // Tie with pointer at A: A write 0x11 @1 first, then B read @1.
        wait_idle();
        issue(0, 1, 1, 'h11, 0, 3);
        issue(1, 0, 1, 0, 'h11, 7);
        wait_acks(7);

        // Lone A read moves the pointer to B.
        wait_idle();
        issue(0, 0, 1, 0, 'h11, 3);
        wait_acks(8);
        check("b_rdata_held", b_rdata, 'h11);

        // Tie with pointer at B: B writes 0x22 @3, then A reads the new data.
        wait_idle();
        issue(1, 1, 3, 'h22, 0, 3);
        issue(0, 0, 3, 0, 'h22, 7);
        wait_acks(10);

        // A writes 0x5A @5, then the read of @5 is aborted by rst in CAPTURE.
        wait_idle();
        issue(0, 1, 5, 'h5A, 0, 3);
        wait_acks(11);
        wait_idle();
        drive(0, 0, 5, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst   = 1'b1;
        a_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        check_clear("mid");

        // Pointer is back at A: tie serves A (@5 now 0) then B (@3 now 0).
        wait_idle();
        issue(0, 0, 5, 0, 'h00, 3);
        issue(1, 0, 3, 0, 'h00, 7);
        wait_acks(13);

        repeat (6) @(negedge clk);
        check("final_ack_count", ack_cnt, 13);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
